// File: rtl/npc_gpr_pkg.sv
// Shared sizing and types for the NPC integer register file.
package npc_gpr_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NR_GPR   = 32;
  localparam int unsigned GPR_AW   = $clog2(NR_GPR);
  localparam int unsigned GPR_ZERO = 0;

  typedef logic [GPR_AW-1:0] gpr_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/gpr_regfile_dirty_tracker.sv
// Tracks which GPRs were written since the last difftest sync and
// publishes a one-cycle-valid snapshot of that set on each sync request.
module gpr_dirty_tracker
  import npc_gpr_pkg::*;
#(
  parameter int unsigned N_REGS = NR_GPR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REGS-1:0] wr_bit,
  input  logic              sync_req,
  output logic              sync_valid,
  output logic [N_REGS-1:0] dirty_snap
);

  logic [N_REGS-1:0] dirty_q, dirty_d;
  logic [N_REGS-1:0] snap_q, snap_d;
  logic              valid_q, valid_d;

  // A write landing in the sync cycle belongs to the outgoing snapshot,
  // so the fresh mask starts empty rather than with that write.
  always_comb begin
    dirty_d = dirty_q | wr_bit;
    snap_d  = snap_q;
    valid_d = sync_req;
    if (sync_req) begin
      snap_d  = dirty_q | wr_bit;
      dirty_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q <= '0;
      snap_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
    end
  end

  assign sync_valid = valid_q;
  assign dirty_snap = snap_q;

endmodule

// File: rtl/gpr_regfile.sv
// RV64 integer register file: two combinational read ports, one WB write
// port, flat architectural-state export, dirty tracking and retire counter.
module gpr_regfile #(
  parameter int unsigned XLEN   = npc_gpr_pkg::XLEN,
  parameter int unsigned NR_GPR = npc_gpr_pkg::NR_GPR,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NR_GPR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          rs1_addr,
  output logic [XLEN-1:0]        rs1_data,
  input  logic [AW-1:0]          rs2_addr,
  output logic [XLEN-1:0]        rs2_data,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   wb_commit,
  input  logic                   sync_req,
  output logic                   sync_valid,
  output logic [NR_GPR-1:0]      dirty_snap,
  output logic [63:0]            commit_cnt,
  output logic [XLEN*NR_GPR-1:0] gpr_flat
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(npc_gpr_pkg::GPR_ZERO);

  // x0 has no storage; index 0 is never referenced.
  logic [XLEN-1:0]   gpr_q [1:NR_GPR-1];
  logic [XLEN-1:0]   gpr_d [1:NR_GPR-1];
  logic [63:0]       commit_cnt_q, commit_cnt_d;
  logic              wr_en;
  logic [NR_GPR-1:0] wr_bit;

  assign wr_en = wb_en && (wb_addr != ZERO_ADDR);

  always_comb begin
    gpr_d = gpr_q;
    for (int unsigned i = 1; i < NR_GPR; i++) begin
      if (wr_en && (wb_addr == AW'(i))) gpr_d[i] = wb_data;
    end
  end

  always_comb begin
    wr_bit = '0;
    if (wr_en) wr_bit[wb_addr] = 1'b1;
  end

  assign commit_cnt_d = commit_cnt_q + {63'b0, wb_commit};

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_q        <= '{default: '0};
      commit_cnt_q <= '0;
    end else begin
      gpr_q        <= gpr_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != ZERO_ADDR) begin
      if ((BYPASS != 0) && wr_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
      else                                                 rs1_data = gpr_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != ZERO_ADDR) begin
      if ((BYPASS != 0) && wr_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
      else                                                 rs2_data = gpr_q[rs2_addr];
    end
  end

  // Export comes straight from storage so difftest sees committed state only.
  always_comb begin
    gpr_flat = '0;
    for (int unsigned i = 1; i < NR_GPR; i++) begin
      gpr_flat[XLEN*i +: XLEN] = gpr_q[i];
    end
  end

  assign commit_cnt = commit_cnt_q;

  gpr_dirty_tracker #(
    .N_REGS(NR_GPR)
  ) u_dirty (
    .clk       (clk),
    .rst       (rst),
    .wr_bit    (wr_bit),
    .sync_req  (sync_req),
    .sync_valid(sync_valid),
    .dirty_snap(dirty_snap)
  );

endmodule
